fetch_queue: RTL and testbench

- Instruction prefetch stage that sits directly upstream of decode.
- Issues word fetches to an instruction memory with variable latency over a req/ack handshake, and buffers returned instructions with their PCs in a FIFO.
- Presents them to decode over a valid/ready interface.
- Handles branch/jump redirects from execute: flushes buffered and in-flight instructions, then restarts fetch at the target.

---
 rtl/fetch_queue.sv | 119 +++++++++++
 tb/tb_fetch_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue between imem and decode
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [7:0]  flush_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t          state, state_nx;
    logic [31:0]     fpc, fpc_nx;
    logic [31:0]     req_addr, req_addr_nx;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     inst_mem [DEPTH];
    logic [31:0]     pc_mem   [DEPTH];
    logic [31:0]     redir_pc;
    logic            push, pop, space;
    logic [CW:0]     next_level;

    assign redir_pc   = redirect_pc & ~32'h3;
    assign out_valid  = (count != '0);
    assign push       = (state == REQ) && imem_ack && !redirect;
    assign pop        = out_valid && out_ready && !redirect;
    assign next_level = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
    assign space      = next_level < (CW+1)'(DEPTH);

    assign imem_req  = (state == REQ) || (state == DRAIN);
    assign imem_addr = req_addr;
    assign out_inst  = out_valid ? inst_mem[rd_ptr] : '0;
    assign out_pc    = out_valid ? pc_mem[rd_ptr]   : '0;

    always_comb begin
        state_nx    = state;
        fpc_nx      = fpc;
        req_addr_nx = req_addr;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fpc_nx      = redir_pc;
                    req_addr_nx = redir_pc;
                    state_nx    = REQ;
                end else if (count < CW'(DEPTH)) begin
                    req_addr_nx = fpc;
                    state_nx    = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    fpc_nx = redir_pc;
                    if (imem_ack) req_addr_nx = redir_pc;
                    else          state_nx    = DRAIN;
                end else if (imem_ack) begin
                    fpc_nx = req_addr + 32'd4;
                    if (space) req_addr_nx = req_addr + 32'd4;
                    else       state_nx    = IDLE;
                end
            end
            DRAIN: begin
                // The stale request must complete before the new stream starts.
                if (redirect) fpc_nx = redir_pc;
                if (imem_ack) begin
                    req_addr_nx = redirect ? redir_pc : fpc;
                    state_nx    = REQ;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fpc       <= RESET_PC;
            req_addr  <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_nx;
            fpc      <= fpc_nx;
            req_addr <= req_addr_nx;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                if (flush_cnt != 8'hFF) flush_cnt <= flush_cnt + 8'd1;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= req_addr;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [7:0]  flush_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int mem_lat = 0;
    int wcnt = 0;
    int ack_total = 0;
    int ack_base;
    logic stale_seen;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: ack after mem_lat waiting cycles, data derived from address.
    assign imem_ack   = imem_req && (wcnt >= mem_lat);
    assign imem_rdata = imem_addr ^ 32'hA5A5A5A5;

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
        if (imem_ack) ack_total <= ack_total + 1;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // 1: streaming with zero-latency memory and an always-ready decoder
        out_ready = 1'b1;
        mem_lat   = 0;
        step();
        chk("rst_req",   32'(imem_req), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_inst",  out_inst, 32'h0);
        chk("rst_pc",    out_pc, 32'h0);
        chk("rst_fcnt",  32'(flush_cnt), 32'h0);
        chk("rst_addr",  imem_addr, 32'h0);
        rst = 1'b0;
        step();
        chk("t1_req",    32'(imem_req), 32'h1);
        chk("t1_addr",   imem_addr, 32'h0);
        chk("t1_nvalid", 32'(out_valid), 32'h0);
        step();
        chk("t1_valid0", 32'(out_valid), 32'h1);
        chk("t1_pc0",    out_pc, 32'h0);
        chk("t1_inst0",  out_inst, 32'hA5A5A5A5);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("t1_valid", 32'(out_valid), 32'h1);
            chk("t1_pc",    out_pc, 32'(4 * k));
            chk("t1_inst",  out_inst, 32'(4 * k) ^ 32'hA5A5A5A5);
        end

        // 2: decoder stalled, queue fills and fetch stops
        out_ready = 1'b0;
        do_reset();
        ack_base = ack_total;
        for (int k = 0; k < 8; k++) step();
        chk("t2_acks",  32'(ack_total - ack_base), 32'd4);
        chk("t2_req",   32'(imem_req), 32'h0);
        chk("t2_valid", 32'(out_valid), 32'h1);
        chk("t2_pc",    out_pc, 32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t2_pop_pc", out_pc, 32'h4);
        step();
        chk("t2_rereq",  32'(imem_req), 32'h1);
        chk("t2_readdr", imem_addr, 32'h10);

        // 3: redirect while a slow request is outstanding
        mem_lat   = 3;
        out_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 40 && !(imem_req && imem_addr == 32'h8); k++) step();
        chk("t3_at8", 32'(imem_req && imem_addr == 32'h8), 32'h1);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        chk("t3_hold_addr", imem_addr, 32'h8);
        chk("t3_hold_req",  32'(imem_req), 32'h1);
        chk("t3_fcnt",      32'(flush_cnt), 32'h1);
        chk("t3_flushed",   32'(out_valid), 32'h0);
        stale_seen = 1'b0;
        for (int k = 0; k < 20 && imem_addr == 32'h8; k++) begin
            step();
            if (out_valid && out_pc != 32'h40) stale_seen = 1'b1;
        end
        chk("t3_new_addr", imem_addr, 32'h40);
        for (int k = 0; k < 20 && !out_valid; k++) begin
            step();
            if (out_valid && out_pc != 32'h40) stale_seen = 1'b1;
        end
        chk("t3_no_stale", 32'(stale_seen), 32'h0);
        chk("t3_out_pc",   out_pc, 32'h40);
        chk("t3_out_inst", out_inst, 32'h40 ^ 32'hA5A5A5A5);

        // 4: redirect coinciding with ack and pop, two entries queued
        mem_lat   = 0;
        out_ready = 1'b0;
        do_reset();
        step();
        step();
        step();
        chk("t4_pre_pc", out_pc, 32'h0);
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk("t4_nvalid", 32'(out_valid), 32'h0);
        chk("t4_addr",   imem_addr, 32'h100);
        chk("t4_fcnt",   32'(flush_cnt), 32'h1);
        step();
        chk("t4_valid",  32'(out_valid), 32'h1);
        chk("t4_pc",     out_pc, 32'h100);

        // 5: asynchronous reset mid-cycle
        out_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) step();
        chk("t5_pre_valid", 32'(out_valid), 32'h1);
        chk("t5_pre_req",   32'(imem_req), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_req",   32'(imem_req), 32'h0);
        chk("t5_async_valid", 32'(out_valid), 32'h0);
        chk("t5_async_addr",  imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("t5_restart_req",  32'(imem_req), 32'h1);
        chk("t5_restart_addr", imem_addr, 32'h0);

        // 6: misaligned redirect from IDLE, then address wrap
        for (int k = 0; k < 4; k++) step();
        chk("t6_idle", 32'(imem_req), 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        step();
        redirect = 1'b0;
        chk("t6_req",   32'(imem_req), 32'h1);
        chk("t6_align", imem_addr, 32'h40);
        chk("t6_fcnt",  32'(flush_cnt), 32'h1);
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFFFFFC;
        step();
        redirect = 1'b0;
        chk("t6_top_addr", imem_addr, 32'hFFFFFFFC);
        chk("t6_fcnt2",    32'(flush_cnt), 32'h2);
        step();
        chk("t6_wrap_addr", imem_addr, 32'h0);
        chk("t6_top_pc",    out_pc, 32'hFFFFFFFC);
        chk("t6_top_inst",  out_inst, 32'h5A5A5A59);
        step();
        chk("t6_wrap_pc",   out_pc, 32'h0);

        // flush counter saturation
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        for (int k = 0; k < 260; k++) step();
        redirect = 1'b0;
        chk("fcnt_sat", 32'(flush_cnt), 32'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
